button_conditioner: RTL



---
 rtl/button_conditioner_pkg.sv | 22 ++
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner_channel.sv | 135 +++++++++++++
 rtl/button_conditioner.sv | 43 ++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared channel indices, channel FSM states and helpers
package chess_input_pkg;

    localparam int BTN_UP          = 0;
    localparam int BTN_DOWN        = 1;
    localparam int BTN_LEFT        = 2;
    localparam int BTN_RIGHT       = 3;
    localparam int BTN_SEL         = 4;
    localparam int NUM_BTN_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button levels in, conditioned level/pulse/repeat out
interface button_conditioner_if
    import chess_input_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] repeat_active;

    // Board / consumer side: drives the pads, reads the conditioned strobes.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  repeat_active
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output repeat_active
    );
endinterface

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: synchronizer, debouncer, press/repeat FSM
module button_channel
    import chess_input_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_pulse_o,
    output logic repeat_active_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_SAT     = {RPT_W{1'b1}};
    localparam logic             ACT_LVL     = (ACTIVE_LOW != 0);

    logic             s1_q;
    logic             s2_q;
    logic             level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             accept_press;
    logic             accept_release;
    btn_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_inc;
    logic             pulse_q, pulse_d;

    // Two-flop synchronizer; polarity is folded in first so reset value 0 means "released".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw_i ^ ACT_LVL;
            s2_q <= s1_q;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d        = level_q;
        db_cnt_d       = '0;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d        = s2_q;
                accept_press   = s2_q;
                accept_release = ~s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Repeat counter never wraps, so a held key cannot alias back to an early pulse.
    assign rpt_cnt_inc = (rpt_cnt_q == RPT_SAT) ? rpt_cnt_q : rpt_cnt_q + 1'b1;

    // Press/repeat FSM; an accepted release wins over any pulse due on the same edge.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        if (accept_release) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_press) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = (REPEAT_EN != 0) ? HOLD : WAIT_REL;
                    end
                end
                HOLD: begin
                    if (rpt_cnt_q == DELAY_LAST) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_inc;
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_q == PERIOD_LAST) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_inc;
                    end
                end
                WAIT_REL: ;
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign btn_level_o     = level_q;
    assign btn_pulse_o     = pulse_q;
    assign repeat_active_o = (state_q == REPEAT);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - NUM_BTN independent conditioned button channels
module button_conditioner
    import chess_input_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_conditioner_if.slave  btn
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] pulse_w;
    logic [NUM_BTN-1:0] rpt_w;

    // Channels share nothing; simultaneous presses give simultaneous pulses, priority is the consumer's call.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk             (clk),
            .reset_n         (reset_n),
            .btn_raw_i       (btn.btn_raw[g]),
            .btn_level_o     (level_w[g]),
            .btn_pulse_o     (pulse_w[g]),
            .repeat_active_o (rpt_w[g])
        );
    end

    assign btn.btn_level     = level_w;
    assign btn.btn_pulse     = pulse_w;
    assign btn.repeat_active = rpt_w;

endmodule
